serial_bit_feeder: RTL and testbench

Parallel-in, serial-out stage that drives the single-bit input of the consecutive-run (4-zeros / 4-ones) detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per bit period. Back-to-back words produce a gap-free bit stream. It also reports framing flags and a count of completed words for the board display.

---
 rtl/serial_bit_feeder.sv | 126 ++++++++++++
 tb/tb_serial_bit_feeder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-in, serial-out word feeder for the consecutive-run detector: WIDTH-bit words in over
// valid/ready, one bit per BIT_CYCLES clocks out, gap-free when words arrive back-to-back.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic             serial_out_q, serial_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;
  logic [7:0]       words_sent_q, words_sent_d;

  logic bit_end;
  logic word_end;
  logic accept;

  assign bit_end    = (cyc_cnt_q == CYC_LAST);
  assign word_end   = (state_q == S_SHIFT) && last_bit_q && bit_end;
  assign load_ready = (state_q == S_IDLE) || word_end;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    serial_out_d = serial_out_q;
    bit_valid_d  = bit_valid_q;
    last_bit_d   = last_bit_q;
    words_sent_d = words_sent_q;

    case (state_q)
      S_IDLE: begin
        serial_out_d = IDLE_BIT;
        bit_valid_d  = 1'b0;
        last_bit_d   = 1'b0;
      end
      S_SHIFT: begin
        if (!bit_end) begin
          cyc_cnt_d = cyc_cnt_q + CW'(1);
        end else if (!last_bit_q) begin
          // shreg holds only the bits not yet driven; the head goes to serial_out next
          cyc_cnt_d    = '0;
          bit_cnt_d    = bit_cnt_q + BW'(1);
          serial_out_d = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
          shreg_d      = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          last_bit_d   = ((bit_cnt_q + BW'(1)) == BIT_LAST);
        end else begin
          words_sent_d = words_sent_q + 8'd1;
          state_d      = S_IDLE;
          shreg_d      = '0;
          bit_cnt_d    = '0;
          cyc_cnt_d    = '0;
          serial_out_d = IDLE_BIT;
          bit_valid_d  = 1'b0;
          last_bit_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new word takes over the output stage, including the end-of-word cycle of the previous one
    if (accept) begin
      state_d      = S_SHIFT;
      shreg_d      = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
      serial_out_d = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
      bit_cnt_d    = '0;
      cyc_cnt_d    = '0;
      bit_valid_d  = 1'b1;
      last_bit_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      serial_out_q <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      last_bit_q   <= 1'b0;
      words_sent_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      serial_out_q <= serial_out_d;
      bit_valid_q  <= bit_valid_d;
      last_bit_q   <= last_bit_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign serial_out = serial_out_q;
  assign bit_valid  = bit_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = (state_q == S_SHIFT);
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two instances (LSB-first/1 cycle per bit, MSB-first/3 cycles per
// bit with idle-high), each checked every cycle against a queue of expected output cycles.
module tb_serial_bit_feeder;

  localparam int BOUND = 400;
  localparam int BC_B  = 3;

  typedef struct packed {
    logic b;
    logic last;
    logic fin;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dat_a, dat_b;
  logic       lv_a, lv_b;
  logic       rdy_a, rdy_b, so_a, so_b, bv_a, bv_b, lb_a, lb_b, busy_a, busy_b;
  logic [7:0] ws_a, ws_b;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] exp_ws_a, exp_ws_b;
  bit         mon_en = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .data_in(dat_a), .load_valid(lv_a), .load_ready(rdy_a),
    .serial_out(so_a), .bit_valid(bv_a), .last_bit(lb_a), .busy(busy_a), .words_sent(ws_a)
  );

  serial_bit_feeder #(.WIDTH(8), .BIT_CYCLES(BC_B), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .reset(reset), .data_in(dat_b), .load_valid(lv_b), .load_ready(rdy_b),
    .serial_out(so_b), .bit_valid(bv_b), .last_bit(lb_b), .busy(busy_b), .words_sent(ws_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected output cycles for one word, pushed at the accept edge
  task automatic push_word(input bit sel, input logic [7:0] d);
    int   bc;
    logic bitv;
    exp_t e;
    bc = sel ? BC_B : 1;
    for (int i = 0; i < 8; i++) begin
      bitv = sel ? d[7-i] : d[i];
      for (int c = 0; c < bc; c++) begin
        e.b    = bitv;
        e.last = (i == 7);
        e.fin  = (i == 7) && (c == bc - 1);
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      qa.delete();
      qb.delete();
      exp_ws_a = 8'd0;
      exp_ws_b = 8'd0;
    end else begin
      if (lv_a && rdy_a) push_word(1'b0, dat_a);
      if (lv_b && rdy_b) push_word(1'b1, dat_b);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check_eq("a_bit_valid", bv_a, qa.size() != 0);
      check_eq("a_busy", busy_a, qa.size() != 0);
      check_eq("a_load_ready", rdy_a, (qa.size() == 0) || qa[0].fin);
      check_eq("a_words_sent", ws_a, exp_ws_a);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check_eq("a_serial_out", so_a, e.b);
        check_eq("a_last_bit", lb_a, e.last);
        if (e.fin) exp_ws_a = exp_ws_a + 8'd1;
      end else begin
        check_eq("a_idle_level", so_a, 0);
        check_eq("a_idle_last", lb_a, 0);
      end

      check_eq("b_bit_valid", bv_b, qb.size() != 0);
      check_eq("b_busy", busy_b, qb.size() != 0);
      check_eq("b_load_ready", rdy_b, (qb.size() == 0) || qb[0].fin);
      check_eq("b_words_sent", ws_b, exp_ws_b);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check_eq("b_serial_out", so_b, e.b);
        check_eq("b_last_bit", lb_b, e.last);
        if (e.fin) exp_ws_b = exp_ws_b + 8'd1;
      end else begin
        check_eq("b_idle_level", so_b, 1);
        check_eq("b_idle_last", lb_b, 0);
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin lv_b = 1'b1; dat_b = d; end
    else     begin lv_a = 1'b1; dat_a = d; end
    while (!(sel ? rdy_b : rdy_a) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check_eq("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    // scramble data after accept: the word in flight must not see it
    if (sel) begin lv_b = 1'b0; dat_b = 8'($urandom); end
    else     begin lv_a = 1'b0; dat_a = 8'($urandom); end
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check_eq("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    lv_a  = 1'b0;
    lv_b  = 1'b0;
    dat_a = 8'h00;
    dat_b = 8'h00;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // single word, LSB first
    send(1'b0, 8'hF0);
    drain(1'b0);
    check_eq("ws_after_f0", ws_a, 1);

    // back-to-back pair, no bubble expected between them
    send(1'b0, 8'h0F);
    send(1'b0, 8'hAA);
    drain(1'b0);
    check_eq("ws_after_b2b", ws_a, 3);

    // MSB first, 3 cycles per bit
    send(1'b1, 8'h80);
    drain(1'b1);
    check_eq("b_ws_after_80", ws_b, 1);
    send(1'b1, 8'h3C);
    send(1'b1, 8'($urandom));
    drain(1'b1);
    check_eq("b_ws_after_more", ws_b, 3);

    // reset in the middle of a word
    send(1'b0, 8'h5A);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_bv", bv_a, 0);
    check_eq("rst_mid_so", so_a, 0);
    check_eq("rst_mid_ws", ws_a, 0);
    check_eq("rst_mid_rdy", rdy_a, 1);
    reset = 1'b0;
    send(1'b0, 8'hC3);
    drain(1'b0);
    check_eq("ws_after_rst", ws_a, 1);

    // counter wrap
    pulse_reset();
    for (int i = 0; i < 256; i++) send(1'b0, 8'($urandom));
    drain(1'b0);
    check_eq("ws_wrap0", ws_a, 0);
    send(1'b0, 8'h81);
    drain(1'b0);
    check_eq("ws_wrap1", ws_a, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
